// File: rtl/usb4_clk_tick_sequencer.sv
// rtl/usb4_clk_tick_sequencer.sv - USB4 lane/FSM/sideband tick enables and sequenced downstream reset
// Single local_clk domain; fractional rates come from carry-out of phase accumulators.
module usb4_clk_tick_sequencer #(
   parameter int         ACC_W         = 16,
   parameter int         GEN2_LANE_INC = 8192,
   parameter int         GEN3_LANE_INC = 16384,
   parameter int         GEN4_LANE_INC = 32768,
   parameter int         GEN2_FSM_INC  = 7944,
   parameter int         GEN3_FSM_INC  = 15887,
   parameter int         GEN4_FSM_INC  = 32768,
   parameter int         SB_DIV        = 80000,
   parameter int         RST_HOLD      = 3,
   parameter int         QUIET_CYCLES  = 16,
   parameter logic [1:0] DEFAULT_GEN   = 2'd2
) (
   input  logic       local_clk,
   input  logic       rst,
   input  logic [1:0] speed_sel,
   input  logic       speed_change_req,
   output logic       speed_change_ack,
   output logic       speed_err,
   output logic [1:0] current_gen,
   output logic       lane_tick,
   output logic       fsm_tick,
   output logic       sb_tick,
   output logic       sub_rst,
   output logic       rst_done
);

   localparam int SB_W    = (SB_DIV > 2) ? $clog2(SB_DIV) : 1;
   localparam int HOLD_W  = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;
   localparam int QUIET_W = (QUIET_CYCLES > 2) ? $clog2(QUIET_CYCLES) : 1;

   localparam logic [SB_W-1:0]    SB_LAST    = SB_W'(SB_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
   localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYCLES - 1);

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      RUN        = 2'd1,
      QUIET      = 2'd2
   } state_t;

   state_t             state;
   logic [SB_W-1:0]    sb_cnt;
   logic [HOLD_W-1:0]  hold_cnt;
   logic [QUIET_W-1:0] quiet_cnt;
   logic [1:0]         pending_gen;
   logic               armed;
   logic [ACC_W-1:0]   lane_acc;
   logic [ACC_W-1:0]   fsm_acc;

   logic [ACC_W-1:0]   lane_inc;
   logic [ACC_W-1:0]   fsm_inc;
   logic [ACC_W:0]     lane_sum;
   logic [ACC_W:0]     fsm_sum;
   logic               sb_wrap;

   always_comb begin
      lane_inc = ACC_W'(GEN4_LANE_INC);
      fsm_inc  = ACC_W'(GEN4_FSM_INC);
      case (current_gen)
         2'd0: begin
            lane_inc = ACC_W'(GEN2_LANE_INC);
            fsm_inc  = ACC_W'(GEN2_FSM_INC);
         end
         2'd1: begin
            lane_inc = ACC_W'(GEN3_LANE_INC);
            fsm_inc  = ACC_W'(GEN3_FSM_INC);
         end
         default: begin
            lane_inc = ACC_W'(GEN4_LANE_INC);
            fsm_inc  = ACC_W'(GEN4_FSM_INC);
         end
      endcase
      lane_sum = {1'b0, lane_acc} + {1'b0, lane_inc};
      fsm_sum  = {1'b0, fsm_acc} + {1'b0, fsm_inc};
      sb_wrap  = (sb_cnt == SB_LAST);
   end

   always_ff @(posedge local_clk) begin
      if (rst) begin
         state            <= RESET_HOLD;
         sb_cnt           <= '0;
         hold_cnt         <= '0;
         quiet_cnt        <= '0;
         pending_gen      <= DEFAULT_GEN;
         armed            <= 1'b1;
         lane_acc         <= '0;
         fsm_acc          <= '0;
         lane_tick        <= 1'b0;
         fsm_tick         <= 1'b0;
         sb_tick          <= 1'b0;
         sub_rst          <= 1'b1;
         rst_done         <= 1'b0;
         current_gen      <= DEFAULT_GEN;
         speed_change_ack <= 1'b0;
         speed_err        <= 1'b0;
      end else begin
         speed_change_ack <= 1'b0;
         speed_err        <= 1'b0;
         sb_cnt           <= sb_wrap ? '0 : sb_cnt + SB_W'(1);
         sb_tick          <= sb_wrap;

         // A held request is consumed once; only a low cycle re-arms it.
         if (!speed_change_req) begin
            armed <= 1'b1;
         end

         case (state)
            RESET_HOLD: begin
               lane_acc  <= '0;
               fsm_acc   <= '0;
               lane_tick <= 1'b0;
               fsm_tick  <= 1'b0;
               sub_rst   <= 1'b1;
               // Leave on the edge that raises the RST_HOLD-th sb_tick.
               if (sb_wrap) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state    <= RUN;
                     sub_rst  <= 1'b0;
                     rst_done <= 1'b1;
                  end else begin
                     hold_cnt <= hold_cnt + HOLD_W'(1);
                  end
               end
            end

            RUN: begin
               lane_acc  <= lane_sum[ACC_W-1:0];
               fsm_acc   <= fsm_sum[ACC_W-1:0];
               lane_tick <= lane_sum[ACC_W];
               fsm_tick  <= fsm_sum[ACC_W];
               if (speed_change_req && armed) begin
                  armed <= 1'b0;
                  if (speed_sel == 2'd3) begin
                     speed_err <= 1'b1;
                  end else begin
                     pending_gen <= speed_sel;
                     quiet_cnt   <= '0;
                     lane_acc    <= '0;
                     fsm_acc     <= '0;
                     lane_tick   <= 1'b0;
                     fsm_tick    <= 1'b0;
                     state       <= QUIET;
                  end
               end
            end

            QUIET: begin
               lane_acc  <= '0;
               fsm_acc   <= '0;
               lane_tick <= 1'b0;
               fsm_tick  <= 1'b0;
               if (quiet_cnt == QUIET_LAST) begin
                  current_gen      <= pending_gen;
                  speed_change_ack <= 1'b1;
                  state            <= RUN;
               end else begin
                  quiet_cnt <= quiet_cnt + QUIET_W'(1);
               end
            end

            default: begin
               state <= RESET_HOLD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_usb4_clk_tick_sequencer.sv
// tb/tb_usb4_clk_tick_sequencer.sv - directed bench for usb4_clk_tick_sequencer
// Expected speed-change outcomes are queued at request time and consumed on ack/err.
module tb_usb4_clk_tick_sequencer;

   localparam int SB_DIV       = 4;
   localparam int RST_HOLD     = 3;
   localparam int QUIET_CYCLES = 16;

   logic       local_clk;
   logic       rst;
   logic [1:0] speed_sel;
   logic       speed_change_req;
   logic       speed_change_ack;
   logic       speed_err;
   logic [1:0] current_gen;
   logic       lane_tick;
   logic       fsm_tick;
   logic       sb_tick;
   logic       sub_rst;
   logic       rst_done;

   usb4_clk_tick_sequencer #(
      .SB_DIV       (SB_DIV),
      .RST_HOLD     (RST_HOLD),
      .QUIET_CYCLES (QUIET_CYCLES)
   ) dut (
      .local_clk        (local_clk),
      .rst              (rst),
      .speed_sel        (speed_sel),
      .speed_change_req (speed_change_req),
      .speed_change_ack (speed_change_ack),
      .speed_err        (speed_err),
      .current_gen      (current_gen),
      .lane_tick        (lane_tick),
      .fsm_tick         (fsm_tick),
      .sb_tick          (sb_tick),
      .sub_rst          (sub_rst),
      .rst_done         (rst_done)
   );

   initial local_clk = 1'b0;
   always #5 local_clk = ~local_clk;

   typedef struct packed {
      logic       is_err;
      logic [1:0] gen;
   } exp_t;

   exp_t exp_q[$];
   int   checks;
   int   failures;
   int   ack_cnt;
   int   err_cnt;
   int   lane_cnt;
   int   fsm_cnt;
   int   last_tick;
   int   first_tick;
   int   spacing_bad;
   int   prev_acks;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Tick expected at RUN cycle j (j=1 is the first accumulating edge), in closed form.
   function automatic logic tick_at(input longint j, input longint inc);
      return ((j * inc) >> 16) != (((j - 1) * inc) >> 16);
   endfunction

   task automatic step();
      exp_t e;
      @(posedge local_clk);
      #1;
      if (speed_change_ack || speed_err) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_event", {30'd0, speed_change_ack, speed_err}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("event_kind", {30'd0, speed_change_ack, speed_err}, e.is_err ? 32'd1 : 32'd2);
            chk("event_gen", {30'd0, current_gen}, {30'd0, e.gen});
         end
         if (speed_change_ack) ack_cnt++;
         if (speed_err) err_cnt++;
      end
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, "_sub_rst"}, {31'd0, sub_rst}, 32'd1);
      chk({pfx, "_rst_done"}, {31'd0, rst_done}, 32'd0);
      chk({pfx, "_gen"}, {30'd0, current_gen}, 32'd2);
      chk({pfx, "_ticks"}, {29'd0, lane_tick, fsm_tick, sb_tick}, 32'd0);
      chk({pfx, "_ack_err"}, {30'd0, speed_change_ack, speed_err}, 32'd0);
   endtask

   task automatic release_seq(input string pfx);
      rst = 1'b0;
      for (int i = 1; i <= SB_DIV * RST_HOLD; i++) begin
         step();
         chk({pfx, "_sub_rst"}, {31'd0, sub_rst}, (i < SB_DIV * RST_HOLD) ? 32'd1 : 32'd0);
         chk({pfx, "_rst_done"}, {31'd0, rst_done}, (i == SB_DIV * RST_HOLD) ? 32'd1 : 32'd0);
         chk({pfx, "_sb_tick"}, {31'd0, sb_tick}, (i % SB_DIV == 0) ? 32'd1 : 32'd0);
         chk({pfx, "_no_ticks"}, {30'd0, lane_tick, fsm_tick}, 32'd0);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      ack_cnt = 0;
      err_cnt = 0;
      rst = 1'b1;
      speed_sel = 2'd0;
      speed_change_req = 1'b0;

      // Reset state, including a request held during reset.
      speed_change_req = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_reset_vals("reset");
      speed_change_req = 1'b0;
      step();
      release_seq("release");

      // Gen4 default: alternating ticks from the second RUN cycle.
      lane_cnt = 0;
      for (int j = 1; j <= 64; j++) begin
         step();
         chk("gen4_lane", {31'd0, lane_tick}, {31'd0, tick_at(j, 32768)});
         chk("gen4_fsm", {31'd0, fsm_tick}, {31'd0, tick_at(j, 32768)});
         if (lane_tick) lane_cnt++;
      end
      chk("gen4_lane_count", lane_cnt, 32);

      // Speed change gen4 -> gen3 with the quiet gap.
      speed_sel = 2'd1;
      speed_change_req = 1'b1;
      exp_q.push_back('{is_err: 1'b0, gen: 2'd1});
      for (int q = 1; q <= QUIET_CYCLES; q++) begin
         step();
         chk("quiet_ticks", {30'd0, lane_tick, fsm_tick}, 32'd0);
         chk("quiet_no_ack", {31'd0, speed_change_ack}, 32'd0);
         chk("quiet_gen", {30'd0, current_gen}, 32'd2);
      end
      step();
      chk("gen3_ack", {31'd0, speed_change_ack}, 32'd1);
      chk("gen3_gen", {30'd0, current_gen}, 32'd1);
      chk("gen3_ack_ticks", {30'd0, lane_tick, fsm_tick}, 32'd0);
      for (int j = 1; j <= 40; j++) begin
         step();
         chk("gen3_lane", {31'd0, lane_tick}, {31'd0, tick_at(j, 16384)});
         chk("gen3_fsm", {31'd0, fsm_tick}, {31'd0, tick_at(j, 15887)});
         if (j == 10) speed_change_req = 1'b0;
      end
      chk("gen3_single_ack", ack_cnt, 1);

      // Illegal speed_sel: one err, ticks keep running at gen3.
      speed_sel = 2'd3;
      speed_change_req = 1'b1;
      exp_q.push_back('{is_err: 1'b1, gen: 2'd1});
      for (int j = 41; j <= 70; j++) begin
         step();
         chk("err_lane", {31'd0, lane_tick}, {31'd0, tick_at(j, 16384)});
         chk("err_fsm", {31'd0, fsm_tick}, {31'd0, tick_at(j, 15887)});
         if (j == 50) speed_change_req = 1'b0;
      end
      chk("err_count", err_cnt, 1);
      chk("err_no_ack", ack_cnt, 1);
      chk("err_gen", {30'd0, current_gen}, 32'd1);

      // Change to gen2, then long-run density and spacing.
      speed_sel = 2'd0;
      speed_change_req = 1'b1;
      exp_q.push_back('{is_err: 1'b0, gen: 2'd0});
      prev_acks = ack_cnt;
      for (int k = 0; k < 40 && ack_cnt == prev_acks; k++) step();
      chk("gen2_ack_arrived", ack_cnt, prev_acks + 1);
      speed_change_req = 1'b0;
      lane_cnt = 0;
      fsm_cnt = 0;
      last_tick = 0;
      first_tick = 0;
      spacing_bad = 0;
      for (int j = 1; j <= 65536; j++) begin
         step();
         if (lane_tick) begin
            lane_cnt++;
            if (first_tick == 0) first_tick = j;
            if (last_tick != 0 && j - last_tick != 8) spacing_bad++;
            last_tick = j;
         end
         if (fsm_tick) fsm_cnt++;
      end
      chk("gen2_lane_count", lane_cnt, 8192);
      chk("gen2_fsm_count", fsm_cnt, 7944);
      chk("gen2_first_tick", first_tick, 8);
      chk("gen2_spacing_bad", spacing_bad, 0);

      // rst in the middle of QUIET: no ack, back to defaults, full hold repeats.
      speed_sel = 2'd1;
      speed_change_req = 1'b1;
      for (int q = 1; q <= 8; q++) begin
         step();
         chk("abort_quiet_ticks", {30'd0, lane_tick, fsm_tick}, 32'd0);
      end
      rst = 1'b1;
      step();
      check_reset_vals("abort_reset");
      speed_change_req = 1'b0;
      step();
      check_reset_vals("abort_reset2");
      release_seq("rerelease");
      for (int j = 1; j <= 20; j++) begin
         step();
         chk("post_abort_gen", {30'd0, current_gen}, 32'd2);
         chk("post_abort_lane", {31'd0, lane_tick}, {31'd0, tick_at(j, 32768)});
      end

      chk("final_ack_count", ack_cnt, 2);
      chk("final_err_count", err_cnt, 1);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
